// File: rtl/bloom_pkg.sv
// bloom_pkg: constants and the window type shared by the window builder and
// the bloom search engine, so that both sides agree on one window layout.
//   BYTE_W       - width of one stream byte
//   MAX_STR_SIZE - window depth in bytes
//   MIN_STR_SIZE - shortest string searched
//   window_t     - window byte array, element [0] is the oldest byte
package bloom_pkg;

  localparam int BYTE_W         = 8;
  localparam int MAX_STR_SIZE   = 20;
  localparam int MIN_STR_SIZE   = 3;
  localparam int MAX_STR_SIZE_W = $clog2(MAX_STR_SIZE) + 1;

  typedef logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] window_t;

endpackage

// File: rtl/bloom_window_builder.sv
// bloom_window_builder: turns a packetised byte stream into the sliding
// windows consumed by the bloom search engine. Every byte position of a packet
// yields one window of up to MAX_STR_SIZE bytes; near the packet tail the
// valid-byte count shrinks down to MIN_STR_SIZE, after which the buffer is
// flushed and the next packet may start.
//
// Ports
//   clk_i                 clock
//   srst_i                synchronous active-high reset
//   data_i                stream byte
//   valid_i               stream byte valid
//   startofpacket_i       first byte of a packet
//   endofpacket_i         last byte of a packet
//   ready_o               stream byte accepted when valid_i && ready_o
//   window_data_o         window, [0] is the oldest byte, unused positions 0
//   window_valid_bytes_o  valid bytes in window, 0 means no window offered
//   window_ready_i        window accepted when window_valid_bytes_o != 0
//                         && window_ready_i
//   protocol_err_o        one-cycle pulse: startofpacket_i inside a packet
//
// Handshakes: both ports use valid/ready. A transfer happens on the rising
// edge where the offer (valid_i, or window_valid_bytes_o != 0) and the
// matching ready are both high. An offered window is held unchanged until it
// is taken. ready_o depends combinationally on window_ready_i so that a byte
// can enter in the same cycle a full window leaves.
module bloom_window_builder #(
  parameter int BYTE_W         = bloom_pkg::BYTE_W,
  parameter int MAX_STR_SIZE   = bloom_pkg::MAX_STR_SIZE,
  parameter int MIN_STR_SIZE   = bloom_pkg::MIN_STR_SIZE,
  parameter int MAX_STR_SIZE_W = $clog2(MAX_STR_SIZE) + 1
) (
  input  logic                                 clk_i,
  input  logic                                 srst_i,
  input  logic [BYTE_W-1:0]                    data_i,
  input  logic                                 valid_i,
  input  logic                                 startofpacket_i,
  input  logic                                 endofpacket_i,
  output logic                                 ready_o,
  output logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]  window_data_o,
  output logic [MAX_STR_SIZE_W-1:0]            window_valid_bytes_o,
  input  logic                                 window_ready_i,
  output logic                                 protocol_err_o
);

  localparam logic [MAX_STR_SIZE_W-1:0] MAX_CNT = MAX_STR_SIZE_W'(MAX_STR_SIZE);
  localparam logic [MAX_STR_SIZE_W-1:0] MIN_CNT = MAX_STR_SIZE_W'(MIN_STR_SIZE);

  // Window buffer and its fill state.
  logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] win_q, win_d;
  logic [MAX_STR_SIZE_W-1:0]           cnt_q, cnt_d;
  logic                                eop_seen_q, eop_seen_d;
  logic                                in_pkt_q, in_pkt_d;
  logic                                err_q, err_d;

  logic w_valid;
  logic w_acc;
  logic byte_acc;
  logic flush;

  // Handshake decode.
  always_comb begin
    w_valid  = (cnt_q == MAX_CNT) || (eop_seen_q && (cnt_q >= MIN_CNT));
    w_acc    = w_valid && window_ready_i;
    ready_o  = !srst_i && !eop_seen_q && ((cnt_q < MAX_CNT) || w_acc);
    byte_acc = valid_i && ready_o;
    // Packet is finished: either the last MIN_STR_SIZE window is being taken,
    // or the packet tail is too short to ever form a window.
    flush    = eop_seen_q && ((w_acc && (cnt_q == MIN_CNT)) || (cnt_q < MIN_CNT));
  end

  // Next-state logic.
  always_comb begin
    win_d      = win_q;
    cnt_d      = cnt_q;
    eop_seen_d = eop_seen_q;
    in_pkt_d   = in_pkt_q;
    err_d      = 1'b0;

    if (flush) begin
      win_d      = '0;
      cnt_d      = '0;
      eop_seen_d = 1'b0;
      in_pkt_d   = 1'b0;
    end else begin
      if (w_acc) begin
        win_d = {BYTE_W'(0), win_q[MAX_STR_SIZE-1:1]};
        cnt_d = cnt_q - 1'b1;
      end
      if (byte_acc) begin
        if (startofpacket_i) begin
          // A new packet always starts from an empty buffer; if one was
          // already open its bytes are dropped and the error is flagged.
          err_d      = in_pkt_q;
          win_d      = '0;
          win_d[0]   = data_i;
          cnt_d      = MAX_STR_SIZE_W'(1);
          in_pkt_d   = 1'b1;
          eop_seen_d = endofpacket_i;
        end else if (in_pkt_q) begin
          // cnt_d already accounts for a shift in this same cycle.
          win_d[cnt_d] = data_i;
          cnt_d        = cnt_d + 1'b1;
          eop_seen_d   = endofpacket_i;
        end
        // Bytes outside any packet are accepted and dropped.
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      win_q      <= '0;
      cnt_q      <= '0;
      eop_seen_q <= 1'b0;
      in_pkt_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      eop_seen_q <= eop_seen_d;
      in_pkt_q   <= in_pkt_d;
      err_q      <= err_d;
    end
  end

  // Outputs depend only on registered state.
  always_comb begin
    window_data_o        = win_q;
    window_valid_bytes_o = w_valid ? cnt_q : '0;
    protocol_err_o       = err_q;
  end

endmodule

// File: tb/tb_bloom_window_builder.sv
module tb_bloom_window_builder;

  localparam int BW   = 8;
  localparam int MAXS = 4;
  localparam int MINS = 2;
  localparam int CW   = 3;
  localparam int DW   = MAXS * BW;
  localparam int EW   = DW + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      srst_i;
  logic [BW-1:0]             data_i;
  logic                      valid_i;
  logic                      sop_i;
  logic                      eop_i;
  logic                      ready_o;
  logic [MAXS-1:0][BW-1:0]   window_data_o;
  logic [CW-1:0]             window_valid_bytes_o;
  logic                      window_ready_i;
  logic                      protocol_err_o;

  bloom_window_builder #(
    .BYTE_W         (BW),
    .MAX_STR_SIZE   (MAXS),
    .MIN_STR_SIZE   (MINS),
    .MAX_STR_SIZE_W (CW)
  ) dut (
    .clk_i                (clk),
    .srst_i               (srst_i),
    .data_i               (data_i),
    .valid_i              (valid_i),
    .startofpacket_i      (sop_i),
    .endofpacket_i        (eop_i),
    .ready_o              (ready_o),
    .window_data_o        (window_data_o),
    .window_valid_bytes_o (window_valid_bytes_o),
    .window_ready_i       (window_ready_i),
    .protocol_err_o       (protocol_err_o)
  );

  int checks     = 0;
  int errors     = 0;
  int err_pulses = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Windows of a complete packet: one per start position i while at least
  // MINS bytes remain, each holding min(MAXS, L-i) bytes, oldest in lane 0.
  function automatic void push_windows(input string s);
    int L;
    int n;
    logic [DW-1:0] d;
    L = s.len();
    for (int i = 0; i + MINS <= L; i++) begin
      n = (L - i < MAXS) ? (L - i) : MAXS;
      d = '0;
      for (int j = 0; j < n; j++) d[j*BW +: BW] = s[i+j];
      exp_q.push_back({CW'(n), d});
    end
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [DW-1:0] prev_data;
  logic [CW-1:0] prev_vb;
  bit            prev_stall = 0;

  always @(negedge clk) begin
    if (srst_i) begin
      prev_stall = 0;
    end else begin
      if (protocol_err_o) err_pulses++;
      if (window_valid_bytes_o != 0) begin
        for (int j = 0; j < MAXS; j++)
          if (j >= int'(window_valid_bytes_o))
            check("tail_zero", 64'(window_data_o[j]), 64'(0));
      end
      if (prev_stall)
        check("stall_hold", 64'({window_valid_bytes_o, window_data_o}), 64'({prev_vb, prev_data}));
      if (window_valid_bytes_o != 0 && window_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got %h expected none", {window_valid_bytes_o, window_data_o});
        end else begin
          check("window", 64'({window_valid_bytes_o, window_data_o}), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = (window_valid_bytes_o != 0) && !window_ready_i;
      prev_data  = window_data_o;
      prev_vb    = window_valid_bytes_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input string s, input bit sop, input bit eop);
    bit got;
    for (int i = 0; i < s.len(); i++) begin
      data_i  = s[i];
      valid_i = 1'b1;
      sop_i   = sop && (i == 0);
      eop_i   = eop && (i == s.len() - 1);
      got     = 0;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clk);
        got = ready_o;
        @(posedge clk);
        #1;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0d of %s got not-accepted expected accepted", i, s);
      end
    end
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && window_valid_bytes_o == 0) break;
      @(posedge clk);
      #1;
    end
    check({name, "_drained"}, 64'(exp_q.size() == 0 && window_valid_bytes_o == 0), 64'(1));
    @(negedge clk);
    check({name, "_ready"}, 64'(ready_o), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Holds the first window of a stream for five cycles.
  task automatic stall_ctrl();
    for (int c = 0; c < 40; c++) begin
      if (window_valid_bytes_o != 0) break;
      @(posedge clk);
      #1;
    end
    window_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_ready_low", 64'(ready_o), 64'(0));
      check("stall_window", 64'({window_valid_bytes_o, window_data_o}), {29'd0, 3'd4, 32'h44434241});
      @(posedge clk);
      #1;
    end
    window_ready_i = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    srst_i         = 1'b1;
    valid_i        = 1'b0;
    sop_i          = 1'b0;
    eop_i          = 1'b0;
    data_i         = '0;
    window_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    srst_i = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_vb", 64'(window_valid_bytes_o), 64'(0));
    check("reset_data", 64'(window_data_o), 64'(0));
    check("reset_err", 64'(protocol_err_o), 64'(0));
    check("reset_ready", 64'(ready_o), 64'(1));
    @(posedge clk);
    #1;

    // Bytes before any start of packet are dropped.
    send("QQ", 0, 0);
    wait_idle("pre_sop");

    // Full packet with the engine always ready.
    push_windows("ABCDEF");
    check("model_count", 64'(exp_q.size()), 64'(5));
    check("model_first", 64'(exp_q[0]), {29'd0, 3'd4, 32'h44434241});
    check("model_last", 64'(exp_q[4]), {29'd0, 3'd2, 32'h00004645});
    send("ABCDEF", 1, 1);
    wait_idle("abcdef");

    // One-byte packet: flushed without a window.
    send("Z", 1, 1);
    @(negedge clk);
    check("z_ready_low", 64'(ready_o), 64'(0));
    check("z_vb", 64'(window_valid_bytes_o), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("z_ready_back", 64'(ready_o), 64'(1));
    check("z_data", 64'(window_data_o), 64'(0));
    check("z_vb_after", 64'(window_valid_bytes_o), 64'(0));
    @(posedge clk);
    #1;

    // Engine stalls on the first window.
    push_windows("ABCDEFGH");
    fork
      send("ABCDEFGH", 1, 1);
      stall_ctrl();
    join
    wait_idle("stall");

    // Start of packet inside an open packet.
    push_windows("XY");
    check("model_xy", 64'(exp_q[0]), {29'd0, 3'd2, 32'h00005958});
    send("ABC", 1, 0);
    send("XY", 1, 1);
    wait_idle("proto");
    check("proto_err_pulses", 64'(err_pulses), 64'(1));

    // Reset while DEF/3 is offered drops the rest of the packet.
    push_windows("ABCDEF");
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    send("ABCDEF", 1, 1);
    for (int c = 0; c < 20; c++) begin
      if (window_valid_bytes_o == 3) break;
      @(posedge clk);
      #1;
    end
    check("rst_saw_def", 64'({window_valid_bytes_o, window_data_o}), {29'd0, 3'd3, 32'h00464544});
    srst_i         = 1'b1;
    window_ready_i = 1'b0;
    @(posedge clk);
    #1;
    srst_i         = 1'b0;
    window_ready_i = 1'b1;
    @(negedge clk);
    check("rst_vb", 64'(window_valid_bytes_o), 64'(0));
    check("rst_data", 64'(window_data_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(1));
    repeat (6) @(posedge clk);
    #1;
    check("rst_queue_empty", 64'(exp_q.size()), 64'(0));

    // Back-to-back packets.
    push_windows("ABCDE");
    push_windows("PQRS");
    check("model_b2b_count", 64'(exp_q.size()), 64'(7));
    check("model_b2b_cde", 64'(exp_q[2]), {29'd0, 3'd3, 32'h00454443});
    send("ABCDE", 1, 1);
    send("PQRS", 1, 1);
    wait_idle("b2b");

    check("total_err_pulses", 64'(err_pulses), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
